// File: rtl/pc_gen_pkg.sv
// ============================================================================
// Module  : pc_gen_pkg
// Brief   : Shared constants, state encoding and alignment helpers for pc_gen.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    localparam int          C_ADDR_W          = 32;
    localparam logic [31:0] C_RESET_PC        = 32'h0000_3000;
    localparam logic [31:0] C_WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        PCG_BOOT = 2'd0,
        PCG_RUN  = 2'd1,
        PCG_HOLD = 2'd2
    } pcg_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & C_WORD_ALIGN_MASK;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_gen_redirect_buf.sv
// ============================================================================
// Module  : pc_gen_redirect_buf
// Brief   : Single-entry pending redirect; EX entries outrank jump entries.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen_redirect_buf
    import pc_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic                ex_valid,
    input  logic [C_ADDR_W-1:0] ex_target,
    input  logic                jump_valid,
    input  logic [C_ADDR_W-1:0] jump_target,
    output logic                pend_v,
    output logic [C_ADDR_W-1:0] pend_tgt,
    output logic                pend_ex
);

    logic                r_pend_v;
    logic [C_ADDR_W-1:0] r_pend_tgt;
    logic                r_pend_ex;

    // A younger jump must never displace an older EX redirect already held
    logic w_jump_wr;
    assign w_jump_wr = jump_valid && !(r_pend_v && r_pend_ex);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_v   <= 1'b0;
            r_pend_tgt <= '0;
            r_pend_ex  <= 1'b0;
        end else if (clear) begin
            r_pend_v   <= 1'b0;
        end else if (load) begin
            if (ex_valid) begin
                r_pend_v   <= 1'b1;
                r_pend_tgt <= ex_target;
                r_pend_ex  <= 1'b1;
            end else if (w_jump_wr) begin
                r_pend_v   <= 1'b1;
                r_pend_tgt <= jump_target;
                r_pend_ex  <= 1'b0;
            end
        end
    end

    assign pend_v   = r_pend_v;
    assign pend_tgt = r_pend_tgt;
    assign pend_ex  = r_pend_ex;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module  : pc_gen
// Brief   : IF-stage program counter with jump/EX redirect and stall holding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        addr_err
);

    pcg_state_t  r_state;
    pcg_state_t  w_state_nxt;
    logic [31:0] r_pc;
    logic        r_flush_if;
    logic        r_flush_id;
    logic        r_addr_err;

    logic        w_pend_v;
    logic [31:0] w_pend_tgt;
    logic        w_pend_ex;

    logic        w_advance;
    logic        w_redir;
    logic        w_redir_ex;
    logic [31:0] w_redir_raw;
    logic [31:0] w_pc_nxt;

    // PC only moves once out of BOOT and with fetch ready
    assign w_advance = !stall && (r_state != PCG_BOOT);

    pc_gen_redirect_buf u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (!w_advance),
        .clear       (w_advance),
        .ex_valid    (ex_valid),
        .ex_target   (ex_target),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .pend_v      (w_pend_v),
        .pend_tgt    (w_pend_tgt),
        .pend_ex     (w_pend_ex)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PCG_BOOT: w_state_nxt = PCG_RUN;
            PCG_RUN:  if (stall)  w_state_nxt = PCG_HOLD;
            PCG_HOLD: if (!stall) w_state_nxt = PCG_RUN;
            default:  w_state_nxt = PCG_BOOT;
        endcase
    end

    // Older (EX) redirects win; live beats pending within the same class
    always_comb begin
        w_redir     = 1'b0;
        w_redir_ex  = 1'b0;
        w_redir_raw = '0;
        if (ex_valid) begin
            w_redir     = 1'b1;
            w_redir_ex  = 1'b1;
            w_redir_raw = ex_target;
        end else if (w_pend_v && w_pend_ex) begin
            w_redir     = 1'b1;
            w_redir_ex  = 1'b1;
            w_redir_raw = w_pend_tgt;
        end else if (jump_valid) begin
            w_redir     = 1'b1;
            w_redir_raw = jump_target;
        end else if (w_pend_v) begin
            w_redir     = 1'b1;
            w_redir_raw = w_pend_tgt;
        end
    end

    assign w_pc_nxt = w_redir ? align_word(w_redir_raw) : pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= PCG_BOOT;
            r_pc       <= RESET_PC;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
            r_addr_err <= 1'b0;
            if (w_advance) begin
                r_pc       <= w_pc_nxt;
                r_flush_if <= w_redir;
                r_flush_id <= w_redir && w_redir_ex;
                r_addr_err <= w_redir && misaligned(w_redir_raw);
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign fetch_valid = (r_state != PCG_BOOT);
    assign flush_if    = r_flush_if;
    assign flush_id    = r_flush_id;
    assign addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module  : tb_pc_gen
// Brief   : Directed self-checking bench for pc_gen.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        ex_valid;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush_if;
    logic        flush_id;
    logic        addr_err;

    integer tests_run;
    integer tests_failed;

    pc_gen #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .ex_valid    (ex_valid),
        .ex_target   (ex_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b0;
        jump_valid = 1'b0; jump_target = '0;
        ex_valid = 1'b0; ex_target = '0;
        tick; tick;
        tests_run++;
        if ({pc, fetch_valid, flush_if, flush_id, addr_err} !== {32'h0000_3000, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h fv=%b fi=%b fd=%b ae=%b, want pc=00003000 all 0",
                     pc, fetch_valid, flush_if, flush_id, addr_err);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({pc, fetch_valid} !== {32'h0000_3000, 1'b0}) begin
            tests_failed++;
            $display("FAIL boot_state: pc=%h fv=%b, want 00003000 0", pc, fetch_valid);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0000_3000;
        exp_pc[1] = 32'h0000_3004;
        exp_pc[2] = 32'h0000_3008;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests_run++;
            if ({pc, pc_plus4, fetch_valid, flush_if} !== {exp_pc[i], exp_pc[i] + 32'd4, 2'b10}) begin
                tests_failed++;
                $display("FAIL seq_%0d: pc=%h p4=%h fv=%b fi=%b, want pc=%h fv=1 fi=0",
                         i, pc, pc_plus4, fetch_valid, flush_if, exp_pc[i]);
            end
        end
    endtask

    task automatic test_jump;
        jump_valid = 1'b1; jump_target = 32'h0000_3100;
        tick;
        jump_valid = 1'b0;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3100, 2'b10}) begin
            tests_failed++;
            $display("FAIL jump_apply: pc=%h fi=%b fd=%b, want 00003100 1 0", pc, flush_if, flush_id);
        end
        tick;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3104, 2'b00}) begin
            tests_failed++;
            $display("FAIL jump_after: pc=%h fi=%b fd=%b, want 00003104 0 0", pc, flush_if, flush_id);
        end
    endtask

    task automatic test_priority;
        jump_valid = 1'b1; jump_target = 32'h0000_3100;
        ex_valid   = 1'b1; ex_target   = 32'h0000_3200;
        tick;
        jump_valid = 1'b0; ex_valid = 1'b0;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3200, 2'b11}) begin
            tests_failed++;
            $display("FAIL ex_over_jump: pc=%h fi=%b fd=%b, want 00003200 1 1", pc, flush_if, flush_id);
        end
        tick;
        tests_run++;
        if (pc !== 32'h0000_3204) begin
            tests_failed++;
            $display("FAIL ex_over_jump_next: pc=%h, want 00003204", pc);
        end
    endtask

    task automatic test_stall_pending;
        stall = 1'b1;
        jump_valid = 1'b1; jump_target = 32'h0000_3100;
        tick;
        jump_valid = 1'b0;
        ex_valid = 1'b1; ex_target = 32'h0000_3400;
        tick;
        ex_valid = 1'b0;
        tick;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3204, 2'b00}) begin
            tests_failed++;
            $display("FAIL stall_hold: pc=%h fi=%b fd=%b, want 00003204 0 0", pc, flush_if, flush_id);
        end
        tests_run++;
        if (fetch_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_fetch_valid: fv=%b, want 1", fetch_valid);
        end
        stall = 1'b0;
        tick;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3400, 2'b11}) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h fi=%b fd=%b, want 00003400 1 1", pc, flush_if, flush_id);
        end
        tick;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3404, 2'b00}) begin
            tests_failed++;
            $display("FAIL jump_lost: pc=%h fi=%b fd=%b, want 00003404 0 0", pc, flush_if, flush_id);
        end
    endtask

    task automatic test_pending_jump;
        stall = 1'b1;
        jump_valid = 1'b1; jump_target = 32'h0000_3100;
        tick;
        jump_valid = 1'b0;
        tick;
        stall = 1'b0;
        tick;
        tests_run++;
        if ({pc, flush_if, flush_id} !== {32'h0000_3100, 2'b10}) begin
            tests_failed++;
            $display("FAIL pend_jump: pc=%h fi=%b fd=%b, want 00003100 1 0", pc, flush_if, flush_id);
        end
        tick;
        tests_run++;
        if (pc !== 32'h0000_3104) begin
            tests_failed++;
            $display("FAIL pend_jump_cleared: pc=%h, want 00003104", pc);
        end
    endtask

    task automatic test_addr_err;
        ex_valid = 1'b1; ex_target = 32'h0000_3402;
        tick;
        ex_valid = 1'b0;
        tests_run++;
        if ({pc, addr_err, flush_id} !== {32'h0000_3400, 2'b11}) begin
            tests_failed++;
            $display("FAIL addr_err_apply: pc=%h ae=%b fd=%b, want 00003400 1 1", pc, addr_err, flush_id);
        end
        tick;
        tests_run++;
        if ({pc, addr_err} !== {32'h0000_3404, 1'b0}) begin
            tests_failed++;
            $display("FAIL addr_err_pulse: pc=%h ae=%b, want 00003404 0", pc, addr_err);
        end
    endtask

    task automatic test_wrap;
        ex_valid = 1'b1; ex_target = 32'hFFFF_FFFC;
        tick;
        ex_valid = 1'b0;
        tests_run++;
        if ({pc, pc_plus4, addr_err} !== {32'hFFFF_FFFC, 32'h0000_0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_top: pc=%h p4=%h ae=%b, want FFFFFFFC 00000000 0", pc, pc_plus4, addr_err);
        end
        tick;
        tests_run++;
        if ({pc, pc_plus4, addr_err} !== {32'h0000_0000, 32'h0000_0004, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_zero: pc=%h p4=%h ae=%b, want 00000000 00000004 0", pc, pc_plus4, addr_err);
        end
    endtask

    task automatic test_reset_mid;
        stall = 1'b1;
        jump_valid = 1'b1; jump_target = 32'h0000_5000;
        tick;
        jump_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({pc, fetch_valid} !== {32'h0000_3000, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h fv=%b, want 00003000 0", pc, fetch_valid);
        end
        tick;
        rst = 1'b1;
        stall = 1'b0;
        tick;
        tests_run++;
        if ({pc, fetch_valid} !== {32'h0000_3000, 1'b1}) begin
            tests_failed++;
            $display("FAIL post_reset_run: pc=%h fv=%b, want 00003000 1", pc, fetch_valid);
        end
        tick;
        tests_run++;
        if ({pc, flush_if} !== {32'h0000_3004, 1'b0}) begin
            tests_failed++;
            $display("FAIL pend_cleared: pc=%h fi=%b, want 00003004 0", pc, flush_if);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset;
        test_sequential;
        test_jump;
        test_priority;
        test_stall_pending;
        test_pending_jump;
        test_addr_err;
        test_wrap;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
